// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the edge-capture PIO poller.
package pio_poll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAP_RD,
    ST_CAP_CHK,
    ST_CLR,
    ST_DAT_RD,
    ST_DAT_CHK,
    ST_EMIT
  } poll_state_e;

  // Register map of the edge-capturing PIO slave.
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_poll_tstamp.sv
// Free-running 32-bit cycle counter used to timestamp captured edges.
// Only instantiated when PIO_POLL_TIMESTAMP_EN is defined.
module pio_poll_tstamp (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] count
);

  // Count every clock, wrapping naturally from 0xFFFF_FFFF to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + 32'd1;
  end

endmodule

// File: rtl/pio_edge_poller.sv
// Avalon-MM master that polls an edge-capturing PIO slave, clears the
// capture register on a hit, reads the data register and emits
// {data, edge mask} on a valid/ready stream.
// Optional feature macro: PIO_POLL_TIMESTAMP_EN adds out_timestamp.
module pio_edge_poller
  import pio_poll_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_edges,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef PIO_POLL_TIMESTAMP_EN
  ,
  output logic [31:0]       out_timestamp
`endif
);

  // Gap counter is loaded with POLL_GAP on entry to WAIT and counts down
  // to zero, so WAIT spans POLL_GAP+1 cycles (one cycle when POLL_GAP=0).
  localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);

  poll_state_e      state;
  logic [GAP_W-1:0] gap_cnt;

  // The slave only ever sees zero on writes; the clear is address-driven.
  assign avm_writedata = '0;

  // Poll sequencer: state and every bus/stream output registered together,
  // with outputs set for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value of the registers.
    if (reset) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      avm_address    <= PIO_ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      out_data       <= '0;
      out_edges      <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Strobes default to idle so each access is exactly one cycle long.
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state          <= ST_CAP_RD;
            avm_address    <= PIO_ADDR_EDGE;
            avm_chipselect <= 1'b1;
            busy           <= 1'b1;
          end
        end
        ST_CAP_RD: state <= ST_CAP_CHK;
        ST_CAP_CHK: begin
          if (avm_readdata != '0) begin
            out_edges      <= avm_readdata;
            state          <= ST_CLR;
            avm_address    <= PIO_ADDR_EDGE;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
          end else begin
            state   <= ST_WAIT;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_CLR: begin
          state          <= ST_DAT_RD;
          avm_address    <= PIO_ADDR_DATA;
          avm_chipselect <= 1'b1;
        end
        ST_DAT_RD: state <= ST_DAT_CHK;
        ST_DAT_CHK: begin
          out_data  <= avm_readdata;
          out_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          // Stall here with data frozen until the consumer accepts it.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (enable) begin
              state   <= ST_WAIT;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (enable) begin
            state          <= ST_CAP_RD;
            avm_address    <= PIO_ADDR_EDGE;
            avm_chipselect <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [31:0] tstamp_now;

  pio_poll_tstamp u_tstamp (
    .clk   (clk),
    .reset (reset),
    .count (tstamp_now)
  );

  // Capture the cycle count at the moment a nonzero edge mask is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_timestamp <= '0;
    else if (state == ST_CAP_CHK && avm_readdata != '0)
      out_timestamp <= tstamp_now;
  end
`else
  // Timestamp feature not built: no counter and no out_timestamp port.
`endif

endmodule
